// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 inter-stage skid register.
// Payload helpers pack {INST, PC, PC4} into the default 96-bit stage payload.
package pipe_pkg;

   localparam int unsigned INST_W    = 32;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned PAYLOAD_W = INST_W + 2 * PC_W;

   localparam logic [INST_W-1:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   pc4;
   } stage_payload_t;

   // Build a payload for a fetched instruction; PC4 is derived from PC.
   function automatic stage_payload_t pack_payload(input logic [INST_W-1:0] inst,
                                                   input logic [PC_W-1:0]   pc);
      stage_payload_t p;
      p.inst = inst;
      p.pc   = pc;
      p.pc4  = pc + PC_W'(4);
      return p;
   endfunction

   // A NOP payload at a given PC, for stages that want a visible bubble.
   function automatic stage_payload_t nop_payload(input logic [PC_W-1:0] pc);
      return pack_payload(RV_NOP, pc);
   endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for the optional stage performance counters.
module pipe_perf_cnt #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   // Sticks at the maximum value instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W = 96,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [15:0]       perf_flush_cnt
`endif
);

   skid_state_e       state, state_d;
   logic [DATA_W-1:0] skid, skid_d;
   logic [DATA_W-1:0] out_data_d;
   logic              out_valid_d;
   logic              in_ready_d;
   logic              acc;
   logic              take;

   assign acc  = in_valid & in_ready;
   assign take = out_valid & out_ready & ~stall;

   // All state and outputs are flops; in_ready/out_valid are re-derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         skid      <= BUBBLE;
         out_data  <= BUBBLE;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_d;
         skid      <= skid_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         in_ready  <= in_ready_d;
      end
   end

   always_comb begin
      state_d    = state;
      skid_d     = skid;
      out_data_d = out_data;

      case (state)
         EMPTY: begin
            if (acc) begin
               state_d    = ONE;
               out_data_d = in_data;
            end
         end
         ONE: begin
            if (acc && take) begin
               out_data_d = in_data;
            end else if (acc) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (take) begin
               state_d    = EMPTY;
               out_data_d = BUBBLE;
            end
         end
         FULL: begin
            if (take) begin
               state_d    = ONE;
               out_data_d = skid;
               skid_d     = BUBBLE;
            end
         end
         default: begin
            state_d    = EMPTY;
            skid_d     = BUBBLE;
            out_data_d = BUBBLE;
         end
      endcase

      // Flush overrides stall and the handshake, and discards any beat accepted this cycle.
      if (flush) begin
         state_d    = EMPTY;
         skid_d     = BUBBLE;
         out_data_d = BUBBLE;
      end

      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != FULL);
   end

`ifdef PIPE_STAGE_PERF_EN
   logic stall_evt;
   logic flush_evt;

   assign stall_evt = out_valid & ~take;
   assign flush_evt = flush & (state != EMPTY);

   pipe_perf_cnt #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_evt),
      .cnt   (perf_stall_cnt)
   );

   pipe_perf_cnt #(.WIDTH(16)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_evt),
      .cnt   (perf_flush_cnt)
   );
`else
   // Counters are absent in this build; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (96-bit payload, zero bubble).
// Perf counter checks run only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

   localparam int unsigned DW = 96;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          stall;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   perf_stall_cnt;
   logic [15:0]   perf_flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   pipe_stage_skid #(.DATA_W(DW), .BUBBLE('0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
      chk({tag, ".out_valid"}, DW'(out_valid), DW'(v));
      chk({tag, ".out_data"},  out_data,       d);
      chk({tag, ".in_ready"},  DW'(in_ready),  DW'(r));
   endtask

   initial begin
      rst_n     = 1'b1;
      flush     = 1'b0;
      stall     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // reset state
      #3 rst_n = 1'b0;
      tick();
      tick();
      chk_out("reset", 1'b0, '0, 1'b1);
      rst_n = 1'b1;
      tick();
      chk_out("post_reset", 1'b0, '0, 1'b1);

      // streaming 1..8, one beat per cycle
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = DW'(i);
         tick();
         chk_out($sformatf("stream%0d", i), 1'b1, DW'(i), 1'b1);
      end
      in_valid = 1'b0;
      tick();
      chk_out("stream_drain", 1'b0, '0, 1'b1);

      // backpressure: A out, B skid, C held upstream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'hA);
      tick();
      chk_out("bp_a", 1'b1, DW'(32'hA), 1'b1);
      in_data = DW'(32'hB);
      tick();
      chk_out("bp_b_full", 1'b1, DW'(32'hA), 1'b0);
      in_data = DW'(32'hC);
      tick();
      chk_out("bp_c_held", 1'b1, DW'(32'hA), 1'b0);
      out_ready = 1'b1;
      tick();
      chk_out("bp_rel_b", 1'b1, DW'(32'hB), 1'b1);
      tick();
      chk_out("bp_rel_c", 1'b1, DW'(32'hC), 1'b1);
      in_valid = 1'b0;
      tick();
      chk_out("bp_drain", 1'b0, '0, 1'b1);

      // flush while FULL with 0xD offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'h1);
      tick();
      in_data = DW'(32'h2);
      tick();
      chk_out("fl_full", 1'b1, DW'(32'h1), 1'b0);
      flush   = 1'b1;
      in_data = DW'(32'hD);
      tick();
      chk_out("fl_cleared", 1'b0, '0, 1'b1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk_out("fl_no_d", 1'b0, '0, 1'b1);

      // flush in ONE discards the beat accepted in the same cycle
      in_valid = 1'b1;
      in_data  = DW'(32'hE);
      tick();
      chk_out("fl1_e", 1'b1, DW'(32'hE), 1'b1);
      flush   = 1'b1;
      in_data = DW'(32'hF);
      tick();
      chk_out("fl1_cleared", 1'b0, '0, 1'b1);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      chk_out("fl1_no_f", 1'b0, '0, 1'b1);

      // stall with out_ready=1 freezes output; input still fills the skid
      in_valid = 1'b1;
      in_data  = DW'(32'h11);
      tick();
      chk_out("st_load", 1'b1, DW'(32'h11), 1'b1);
      in_valid = 1'b0;
      stall    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("st_hold%0d", i), 1'b1, DW'(32'h11), 1'b1);
      end
      in_valid = 1'b1;
      in_data  = DW'(32'h22);
      tick();
      chk_out("st_fill", 1'b1, DW'(32'h11), 1'b0);
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      chk_out("st_flush", 1'b0, '0, 1'b1);
      flush = 1'b0;
      stall = 1'b0;
      tick();
      chk_out("st_after", 1'b0, '0, 1'b1);

      // async reset mid-stream while FULL
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'h31);
      tick();
      in_data = DW'(32'h32);
      tick();
      chk_out("rst_full", 1'b1, DW'(32'h31), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_out("rst_async", 1'b0, '0, 1'b1);
      #1 rst_n = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk_out("rst_release", 1'b0, '0, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
      // 5 stalled cycles, then 2 flushes with a live entry (plus one ineffective flush)
      chk("perf_stall_rst", DW'(perf_stall_cnt), DW'(0));
      chk("perf_flush_rst", DW'(perf_flush_cnt), DW'(0));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(32'h41);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      out_ready = 1'b1;
      tick();
      chk("perf_stall5", DW'(perf_stall_cnt), DW'(5));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(32'h50 + i);
         tick();
         in_valid = 1'b0;
         flush    = 1'b1;
         tick();
         flush = 1'b0;
      end
      chk("perf_stall_final", DW'(perf_stall_cnt), DW'(5));
      chk("perf_flush2", DW'(perf_flush_cnt), DW'(2));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
